// File: rtl/backoff_engine.sv
// backoff_engine: independent per-channel exponential backoff timers.
// Each channel owns a 4-state FSM, a countdown and an exponent. The wait
// length is BASE_CYC << exp. A timed-out wait bumps the exponent up to
// MAX_EXP. An interrupted wait leaves the exponent alone. success_i clears
// the exponent at any time.
module backoff_engine #(
    parameter int NUM_CH   = 4,
    parameter int BASE_CYC = 4,
    parameter int MAX_EXP  = 10,
    parameter int CNT_W    = 16,
    parameter int EXP_W    = $clog2(MAX_EXP + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       valid_i,
    input  logic [NUM_CH-1:0]       interrupt_i,
    input  logic [NUM_CH-1:0]       success_i,
    output logic [NUM_CH-1:0]       ack_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH*EXP_W-1:0] exp_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  BASE_V   = CNT_W'(BASE_CYC);
    localparam logic [EXP_W-1:0]  EXP_MAX  = EXP_W'(MAX_EXP);
    localparam longint unsigned   MAX_WAIT = longint'(BASE_CYC) << MAX_EXP;
    localparam longint unsigned   CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

    // The longest wait must be representable in the countdown register.
    if (MAX_WAIT > CNT_MAX) begin : g_cnt_w_check
        $error("backoff_engine: BASE_CYC << MAX_EXP does not fit in CNT_W bits");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_tmo;
        logic             w_tmo_nxt;
        logic [EXP_W-1:0] r_exp;
        logic [EXP_W-1:0] w_exp_nxt;
        logic             r_ack;
        logic             r_busy;
        logic [CNT_W-1:0] w_load;

        // Reload value for a fresh wait. The load edge already counts as the
        // first cycle of the wait.
        assign w_load = (BASE_V << r_exp) - CNT_W'(1);

        // Next-state and countdown logic for one channel.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_tmo_nxt   = r_tmo;
            case (r_state)
                ST_IDLE: begin
                    if (valid_i[g]) begin
                        if (interrupt_i[g]) begin
                            w_state_nxt = ST_ACK;
                            w_tmo_nxt   = 1'b0;
                        end else if (w_load == '0) begin
                            // Single-cycle wait: the load edge is the whole wait.
                            w_state_nxt = ST_ACK;
                            w_tmo_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_COUNT;
                            w_cnt_nxt   = w_load;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (!valid_i[g]) begin
                        // Requester withdrew: silent abort, no ack.
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (interrupt_i[g]) begin
                        w_state_nxt = ST_ACK;
                        w_tmo_nxt   = 1'b0;
                    end else if (r_cnt <= CNT_W'(1)) begin
                        // The final decrement would reach zero: timeout.
                        w_state_nxt = ST_ACK;
                        w_tmo_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (valid_i[g]) begin
                        w_state_nxt = ST_WAIT_LOW;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!valid_i[g]) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_LOW;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = 1'b0;
                end
            endcase
        end

        // Exponent update: success wins over the timeout increment.
        always_comb begin
            w_exp_nxt = r_exp;
            if (success_i[g]) begin
                w_exp_nxt = '0;
            end else if ((r_state == ST_ACK) && r_tmo && (r_exp != EXP_MAX)) begin
                w_exp_nxt = r_exp + EXP_W'(1);
            end else begin
                w_exp_nxt = r_exp;
            end
        end

        // Channel state, counters and registered outputs.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_tmo   <= 1'b0;
                r_exp   <= '0;
                r_ack   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_tmo   <= w_tmo_nxt;
                r_exp   <= w_exp_nxt;
                r_ack   <= (w_state_nxt == ST_ACK);
                r_busy  <= (w_state_nxt == ST_COUNT) || (w_state_nxt == ST_ACK);
            end
        end

        assign ack_o[g]                 = r_ack;
        assign busy_o[g]                = r_busy;
        assign exp_o[g*EXP_W +: EXP_W]  = r_exp;
    end

endmodule
